// File: rtl/root_hub_router_if.sv
// rtl/root_hub_router_if.sv - per-channel rx/tx message bundle between router and channel FIFOs
interface root_hub_router_if #(
  parameter int N             = 5,
  parameter int CHANNEL_WIDTH = 64
);
  logic [CHANNEL_WIDTH*N-1:0] rx_data;
  logic [N-1:0]               rx_valid;
  logic [N-1:0]               rx_ready;
  logic [CHANNEL_WIDTH*N-1:0] tx_data;
  logic [N-1:0]               tx_valid;
  logic [N-1:0]               tx_ready;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready,
    input  tx_data, tx_valid,
    output tx_ready
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready,
    output tx_data, tx_valid,
    input  tx_ready
  );
endinterface

// File: rtl/root_hub_router.sv
// rtl/root_hub_router.sv - destination-routed message switch: controller plus NUM_LEAVES leaves, RR arbitration, broadcast, drop counting
module root_hub_router #(
  parameter int                    NUM_LEAVES    = 4,
  parameter int                    CHANNEL_WIDTH = 64,
  parameter int                    DEST_WIDTH    = 8,
  parameter logic [DEST_WIDTH-1:0] BCAST_DEST    = 8'hFF
) (
  input  logic             clk,
  input  logic             reset,
  root_hub_router_if.slave bus,
  output logic [15:0]      drop_count
);
  localparam int N  = NUM_LEAVES + 1;
  localparam int PW = $clog2(N);

  logic [CHANNEL_WIDTH*N-1:0] tx_data_q, tx_data_d;
  logic [N-1:0]               tx_valid_q, tx_valid_d;
  logic [PW-1:0]              ptr_q [N];
  logic [PW-1:0]              ptr_d [N];
  logic [PW-1:0]              bb_ptr_q, bb_ptr_d;
  logic [NUM_LEAVES:1]        bb_mask_q, bb_mask_d;
  logic [CHANNEL_WIDTH-1:0]   bb_data_q, bb_data_d;
  logic [15:0]                drop_q, drop_d;

  logic [CHANNEL_WIDTH-1:0]   rx_msg [N];
  int                         dest [N];
  logic [N-1:0]               is_uni, is_bc, is_drop;
  logic [N-1:0]               loadable, bb_claim, rx_ready_int;

  always_comb begin
    logic                found;
    int                  win;
    int                  idx;
    int                  ndrop;
    logic [16:0]         drop_sum;
    logic [NUM_LEAVES:1] fill_mask;

    found        = 1'b0;
    win          = 0;
    idx          = 0;
    ndrop        = 0;
    drop_sum     = '0;
    fill_mask    = '1;
    rx_msg       = '{default: '0};
    dest         = '{default: 0};
    is_uni       = '0;
    is_bc        = '0;
    is_drop      = '0;
    loadable     = '0;
    bb_claim     = '0;
    rx_ready_int = '0;
    tx_valid_d   = tx_valid_q & ~bus.tx_ready;
    tx_data_d    = tx_data_q;
    ptr_d        = ptr_q;
    bb_ptr_d     = bb_ptr_q;
    bb_mask_d    = bb_mask_q;
    bb_data_d    = bb_data_q;

    for (int s = 0; s < N; s++) begin
      rx_msg[s]  = bus.rx_data[CHANNEL_WIDTH*s +: CHANNEL_WIDTH];
      dest[s]    = int'(rx_msg[s][CHANNEL_WIDTH-1 -: DEST_WIDTH]);
      is_uni[s]  = bus.rx_valid[s] && (dest[s] <= NUM_LEAVES) && (dest[s] != s);
      is_bc[s]   = bus.rx_valid[s] && (dest[s] > NUM_LEAVES) &&
                   (rx_msg[s][CHANNEL_WIDTH-1 -: DEST_WIDTH] == BCAST_DEST);
      is_drop[s] = bus.rx_valid[s] && !is_uni[s] && !is_bc[s];
      loadable[s] = !tx_valid_q[s] || bus.tx_ready[s];
    end

    // Broadcast drain claims its leaves before any unicast arbitration on them
    for (int c = 1; c < N; c++) begin
      bb_claim[c] = bb_mask_q[c] && loadable[c];
      if (bb_claim[c]) begin
        bb_mask_d[c]                                  = 1'b0;
        tx_valid_d[c]                                 = 1'b1;
        tx_data_d[CHANNEL_WIDTH*c +: CHANNEL_WIDTH]   = bb_data_q;
      end
    end

    for (int c = 0; c < N; c++) begin
      found = 1'b0;
      win   = 0;
      for (int k = 0; k < N; k++) begin
        idx = int'(ptr_q[c]) + k;
        if (idx >= N) idx = idx - N;
        if (!found && is_uni[idx] && dest[idx] == c) begin
          found = 1'b1;
          win   = idx;
        end
      end
      if (found && loadable[c] && !bb_claim[c]) begin
        rx_ready_int[win]                           = 1'b1;
        tx_valid_d[c]                               = 1'b1;
        tx_data_d[CHANNEL_WIDTH*c +: CHANNEL_WIDTH] = rx_msg[win];
        ptr_d[c]                                    = (win == N - 1) ? '0 : PW'(win + 1);
      end
    end

    // Refill only from an empty buffer, so it can never refill in the cycle it drains its last leaf
    if (bb_mask_q == '0) begin
      found = 1'b0;
      win   = 0;
      for (int k = 0; k < N; k++) begin
        idx = int'(bb_ptr_q) + k;
        if (idx >= N) idx = idx - N;
        if (!found && is_bc[idx]) begin
          found = 1'b1;
          win   = idx;
        end
      end
      if (found) begin
        fill_mask = '1;
        if (win >= 1) fill_mask[win] = 1'b0;
        rx_ready_int[win] = 1'b1;
        bb_mask_d         = fill_mask;
        bb_data_d         = rx_msg[win];
        bb_ptr_d          = (win == N - 1) ? '0 : PW'(win + 1);
      end
    end

    rx_ready_int = rx_ready_int | is_drop;
    ndrop        = $countones(is_drop);
    drop_sum     = {1'b0, drop_q} + 17'(ndrop);
    drop_d       = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_data_q  <= '0;
      tx_valid_q <= '0;
      for (int c = 0; c < N; c++) ptr_q[c] <= '0;
      bb_ptr_q   <= '0;
      bb_mask_q  <= '0;
      bb_data_q  <= '0;
      drop_q     <= '0;
    end else begin
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      ptr_q      <= ptr_d;
      bb_ptr_q   <= bb_ptr_d;
      bb_mask_q  <= bb_mask_d;
      bb_data_q  <= bb_data_d;
      drop_q     <= drop_d;
    end
  end

  assign bus.rx_ready = reset ? rx_ready_int : '0;
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_valid = tx_valid_q;
  assign drop_count   = drop_q;
endmodule

// File: tb/tb_root_hub_router.sv
// tb/tb_root_hub_router.sv - directed self-checking bench for root_hub_router (NUM_LEAVES=4)
module tb_root_hub_router;
  localparam int N  = 5;
  localparam int CW = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] drop_count;
  int          total = 0;
  int          bad   = 0;

  root_hub_router_if #(.N(N), .CHANNEL_WIDTH(CW)) bus ();

  root_hub_router #(
    .NUM_LEAVES(4), .CHANNEL_WIDTH(CW), .DEST_WIDTH(8), .BCAST_DEST(8'hFF)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic put(input int c, input logic [7:0] d, input logic [55:0] p);
    bus.rx_data[CW*c +: CW] = {d, p};
    bus.rx_valid[c]         = 1'b1;
  endtask

  function automatic logic [63:0] txd(input int c);
    return bus.tx_data[CW*c +: CW];
  endfunction

  int exp_src [6] = '{1, 2, 3, 1, 2, 3};

  initial begin
    reset        = 1'b0;
    bus.rx_data  = '0;
    bus.rx_valid = '0;
    bus.tx_ready = '1;
    for (int c = 0; c < N; c++) put(c, 8'h07, 56'h0);
    #2;
    chk("reset_rx_ready", 64'(bus.rx_ready), 64'h0);
    chk("reset_tx_valid", 64'(bus.tx_valid), 64'h0);
    tick();
    chk("reset_drop", 64'(drop_count), 64'h0);
    bus.rx_valid = '0;
    tick();
    reset = 1'b1;

    // unicast ch0 -> leaf 2
    put(0, 8'h02, 56'h00_0000_0000_00AB);
    #1 chk("uni_rx_ready", 64'(bus.rx_ready), 64'h01);
    tick();
    bus.rx_valid = '0;
    chk("uni_tx_valid", 64'(bus.tx_valid), 64'h04);
    chk("uni_tx_data", txd(2), 64'h0200_0000_0000_00AB);
    chk("uni_drop", 64'(drop_count), 64'h0);
    tick();
    chk("uni_tx_clear", 64'(bus.tx_valid), 64'h0);

    // contention on output 0
    put(1, 8'h00, 56'h11);
    put(2, 8'h00, 56'h22);
    put(3, 8'h00, 56'h33);
    for (int i = 0; i < 6; i++) begin
      #1 chk("rr_rx_ready", 64'(bus.rx_ready), 64'(1 << exp_src[i]));
      tick();
      chk("rr_tx_valid", 64'(bus.tx_valid), 64'h01);
      chk("rr_tx_data", txd(0), {8'h00, 56'(exp_src[i] * 56'h11)});
    end
    bus.rx_valid = '0;
    tick();

    // back-pressure on leaf 3
    bus.tx_ready[3] = 1'b0;
    put(0, 8'h03, 56'h100);
    #1 chk("bp_first_accept", 64'(bus.rx_ready), 64'h01);
    tick();
    put(0, 8'h03, 56'h101);
    for (int i = 0; i < 10; i++) begin
      #1 chk("bp_stall_ready", 64'(bus.rx_ready[0]), 64'h0);
      tick();
      chk("bp_hold_data", txd(3), {8'h03, 56'h100});
      chk("bp_hold_valid", 64'(bus.tx_valid[3]), 64'h1);
    end
    bus.tx_ready[3] = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      #1 chk("bp_stream_ready", 64'(bus.rx_ready[0]), 64'h1);
      tick();
      chk("bp_stream_data", txd(3), {8'h03, 56'(56'h100 + k)});
      put(0, 8'h03, 56'(56'h101 + k));
    end
    bus.rx_valid = '0;
    tick();
    chk("bp_drained", 64'(bus.tx_valid), 64'h0);

    // broadcast from ch2 with leaf 4 occupied
    bus.tx_ready[4] = 1'b0;
    put(0, 8'h04, 56'hA4);
    #1 chk("bc_pre_ready", 64'(bus.rx_ready), 64'h01);
    tick();
    bus.rx_valid = '0;
    chk("bc_pre_valid", 64'(bus.tx_valid), 64'h10);
    put(2, 8'hFF, 56'hB2);
    #1 chk("bc_fill_ready", 64'(bus.rx_ready), 64'h04);
    tick();
    chk("bc_fill_valid", 64'(bus.tx_valid), 64'h10);
    bus.rx_valid = '0;
    put(0, 8'hFF, 56'hB0);
    #1 chk("bc_stall0", 64'(bus.rx_ready), 64'h0);
    tick();
    chk("bc_leaves13", 64'(bus.tx_valid), 64'h1A);
    chk("bc_leaf1_data", txd(1), {8'hFF, 56'hB2});
    chk("bc_leaf3_data", txd(3), {8'hFF, 56'hB2});
    chk("bc_leaf4_held", txd(4), {8'h04, 56'hA4});
    #1 chk("bc_stall1", 64'(bus.rx_ready), 64'h0);
    tick();
    chk("bc_wait4", 64'(bus.tx_valid), 64'h10);
    bus.tx_ready[4] = 1'b1;
    #1 chk("bc_stall2", 64'(bus.rx_ready), 64'h0);
    tick();
    chk("bc_leaf4_valid", 64'(bus.tx_valid), 64'h10);
    chk("bc_leaf4_data", txd(4), {8'hFF, 56'hB2});
    #1 chk("bc2_fill_ready", 64'(bus.rx_ready), 64'h01);
    tick();
    bus.rx_valid = '0;
    chk("bc2_fill_valid", 64'(bus.tx_valid), 64'h0);
    tick();
    chk("bc2_all_valid", 64'(bus.tx_valid), 64'h1E);
    for (int c = 1; c <= 4; c++) chk("bc2_data", txd(c), {8'hFF, 56'hB0});
    tick();
    chk("bc2_clear", 64'(bus.tx_valid), 64'h0);

    // drops: self-addressed and out-of-range
    put(1, 8'h01, 56'hD1);
    put(2, 8'h07, 56'hD2);
    #1 chk("drop_ready", 64'(bus.rx_ready), 64'h06);
    tick();
    bus.rx_valid = '0;
    chk("drop_tx_valid", 64'(bus.tx_valid), 64'h0);
    chk("drop_count2", 64'(drop_count), 64'h2);

    // async reset in the middle of a broadcast drain
    bus.tx_ready[4] = 1'b0;
    put(0, 8'h04, 56'hA4);
    tick();
    bus.rx_valid = '0;
    put(1, 8'hFF, 56'hC1);
    tick();
    bus.rx_valid = '0;
    chk("rst_fill_valid", 64'(bus.tx_valid), 64'h10);
    tick();
    chk("rst_partial", 64'(bus.tx_valid), 64'h1C);
    #3 reset = 1'b0;
    #1;
    chk("rst_async_valid", 64'(bus.tx_valid), 64'h0);
    chk("rst_async_drop", 64'(drop_count), 64'h0);
    chk("rst_async_ready", 64'(bus.rx_ready), 64'h0);
    tick();
    tick();
    reset        = 1'b1;
    bus.tx_ready = '1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_no_stale", 64'(bus.tx_valid), 64'h0);
    end

    // saturation of drop_count
    for (int c = 0; c < N; c++) put(c, 8'h07, 56'hEE);
    repeat (13106) @(posedge clk);
    #1;
    bus.rx_valid = 5'b00110;
    repeat (2) @(posedge clk);
    #1 chk("sat_fffe", 64'(drop_count), 64'hFFFE);
    tick();
    chk("sat_ffff", 64'(drop_count), 64'hFFFF);
    bus.rx_valid = '1;
    tick();
    chk("sat_hold", 64'(drop_count), 64'hFFFF);
    bus.rx_valid = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
